mul_arb_sched: RTL and testbench

MUL_ARB_SCHED -- requirements
Module: mul_arb_sched

---
 rtl/mul_arb_sched.sv | 166 ++++++++++++++++
 tb/tb_mul_arb_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arb_sched.sv
// mul_arb_sched: round-robin arbiter that schedules NREQ requesters onto one
// shared, pipelined 8x8 Booth multiplier and routes each product back to the
// requester that issued it.
//
// Optional feature: define MUL_ARB_TAG_CHECK_EN to add the sticky tag_err
// output, which cross-checks the multiplier's valid against the local tag.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   en                     allow new grants (in-flight work always completes)
//   req_valid/req_ready    per-requester handshake; req_ready is combinational, one-hot or zero
//   req_a/req_b/req_sm     per-requester operands (8 bits each) and sign mode (2 bits)
//   mul_v_in/a/b/sm        registered issue port to the multiplier
//   mul_p/mul_v_out        multiplier result, LAT cycles after mul_v_in
//   rsp_valid/rsp_p/rsp_id registered one-cycle response pulse, product, owner id
//   busy                   draining after reset, or a tag still in flight
//   tag_err                (MUL_ARB_TAG_CHECK_EN only) sticky tag/valid disagreement
module mul_arb_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [8*NREQ-1:0]       req_a,
    input  logic [8*NREQ-1:0]       req_b,
    input  logic [2*NREQ-1:0]       req_sm,
    output logic                    mul_v_in,
    output logic [7:0]              mul_a,
    output logic [7:0]              mul_b,
    output logic [1:0]              mul_sm,
    input  logic [15:0]             mul_p,
    input  logic                    mul_v_out,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [15:0]             rsp_p,
    output logic [$clog2(NREQ)-1:0] rsp_id,
`ifdef MUL_ARB_TAG_CHECK_EN
    output logic                    tag_err,
`endif
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LAT + 1) + 1;

    typedef enum logic {DRAIN = 1'b0, RUN = 1'b1} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [LAT:0]           tag_v_q, tag_v_d;
    logic [LAT:0][IDW-1:0]  tag_id_q, tag_id_d;
    logic                   mul_v_in_q, mul_v_in_d;
    logic [7:0]             mul_a_q, mul_a_d;
    logic [7:0]             mul_b_q, mul_b_d;
    logic [1:0]             mul_sm_q, mul_sm_d;
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [15:0]            rsp_p_q, rsp_p_d;
    logic [IDW-1:0]         rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]        gnt;
    logic [IDW-1:0]         gnt_id;
    logic                   hs;
    logic                   rsp_fire;

    // Round-robin search starting just after the last served requester.
    // The grant only ever lands on a valid requester, so grant == handshake.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        hs     = 1'b0;
        if (state_q == RUN && en) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!hs && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                    gnt[(int'(ptr_q) + k) % NREQ] = 1'b1;
                    gnt_id = IDW'((int'(ptr_q) + k) % NREQ);
                    hs     = 1'b1;
                end
            end
        end
    end

    // A response is only taken in RUN: in DRAIN the un-reset multiplier may
    // still be emitting stale valids from before reset.
`ifdef MUL_ARB_TAG_CHECK_EN
    assign rsp_fire = (state_q == RUN) && mul_v_out && tag_v_q[LAT];
`else
    assign rsp_fire = (state_q == RUN) && mul_v_out;
`endif

    always_comb begin
        ptr_d       = hs ? gnt_id : ptr_q;
        mul_v_in_d  = hs;
        mul_a_d     = hs ? req_a[8*gnt_id +: 8]  : mul_a_q;
        mul_b_d     = hs ? req_b[8*gnt_id +: 8]  : mul_b_q;
        mul_sm_d    = hs ? req_sm[2*gnt_id +: 2] : mul_sm_q;
        // Tag stage k lines up with the multiplier's stage k; the tail
        // (stage LAT) is valid in the same cycle as the matching mul_v_out.
        tag_v_d     = {tag_v_q[LAT-1:0], hs};
        tag_id_d    = {tag_id_q[LAT-1:0], gnt_id};
        rsp_valid_d = rsp_fire ? (NREQ'(1) << tag_id_q[LAT]) : '0;
        rsp_p_d     = rsp_fire ? mul_p : rsp_p_q;
        rsp_id_d    = rsp_fire ? tag_id_q[LAT] : rsp_id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DRAIN;
            cnt_q       <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            mul_v_in_q  <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_sm_q    <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                // LAT+1 cycles is enough for every stale multiplier valid to fall out.
                DRAIN: begin
                    if (cnt_q == CW'(LAT)) state_q <= RUN;
                    else                   cnt_q   <= cnt_q + 1'b1;
                end
                RUN:     state_q <= RUN;
                default: state_q <= DRAIN;
            endcase
            ptr_q       <= ptr_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            mul_v_in_q  <= mul_v_in_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_sm_q    <= mul_sm_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

`ifdef MUL_ARB_TAG_CHECK_EN
    logic tag_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                               tag_err_q <= 1'b0;
        else if (state_q == RUN && (mul_v_out != tag_v_q[LAT])) tag_err_q <= 1'b1;
    end

    assign tag_err = tag_err_q;
`endif

    assign req_ready = gnt;
    assign mul_v_in  = mul_v_in_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_sm    = mul_sm_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q == DRAIN) || (|tag_v_q);

endmodule

// File: tb/tb_mul_arb_sched.sv
// Scoreboard bench for mul_arb_sched (NREQ=4, LAT=7) with a behavioural,
// un-reset multiplier model. The driver checks grants and queues the
// hand-computed product and due cycle; a negedge monitor pops and compares.
module tb_mul_arb_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [7:0]  req_sm = '0;
    logic        mul_v_in;
    logic [7:0]  mul_a, mul_b;
    logic [1:0]  mul_sm;
    logic [15:0] mul_p;
    logic        mul_v_out;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_p;
    logic [1:0]  rsp_id;
    logic        busy;
`ifdef MUL_ARB_TAG_CHECK_EN
    logic        tag_err;
`endif

    mul_arb_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sm(req_sm),
        .mul_v_in(mul_v_in), .mul_a(mul_a), .mul_b(mul_b), .mul_sm(mul_sm),
        .mul_p(mul_p), .mul_v_out(mul_v_out),
        .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_id(rsp_id),
`ifdef MUL_ARB_TAG_CHECK_EN
        .tag_err(tag_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: LAT stages, never reset; valid pipe starts full of
    // garbage so the drain period has something stale to discard.
    logic [LAT-1:0]       sv = '1;
    logic [LAT-1:0][15:0] sp = '0;
    logic                 stub_force = 1'b0;
    logic [15:0]          prod;

    always_comb begin
        prod = 16'({{8{mul_sm[1] & mul_a[7]}}, mul_a} * {{8{mul_sm[0] & mul_b[7]}}, mul_b});
    end

    always @(posedge clk) begin
        sv <= {sv[LAT-2:0], mul_v_in};
        sp <= {sp[LAT-2:0], prod};
    end

    assign mul_v_out = sv[LAT-1] | stub_force;
    assign mul_p     = sp[LAT-1];

    typedef struct {
        logic [1:0]  id;
        logic [15:0] p;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_rsp: got rsp_valid 0x%0h id %0d p 0x%0h, expected none (cycle %0d)",
                         rsp_valid, rsp_id, rsp_p, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.id));
                chk("rsp_id",    32'(rsp_id),    32'(e.id));
                chk("rsp_p",     32'(rsp_p),     32'(e.p));
                chk("rsp_cycle", 32'(cyc),       32'(e.due));
            end
        end
    end

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] sm);
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_sm[2*i +: 2] = sm;
    endtask

    // One cycle: drive req_valid, check the grant, queue the expected response.
    task automatic cycle(input logic [3:0] v, input logic [3:0] er, input logic [15:0] ep, input bit push);
        exp_t e;
        req_valid = v;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        if (push && er != '0) begin
            e.id = '0;
            for (int i = 0; i < 4; i++) if (er[i]) e.id = 2'(i);
            e.p   = ep;
            e.due = cyc + LAT + 2;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0000, 4'b0000, 16'h0, 1'b0);
    endtask

    task automatic drain_check(input string tag);
        for (int i = 0; i < LAT + 1; i++) begin
            #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            cycle(4'b1111, 4'b0000, 16'h0, 1'b0);
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_mul_v_in",  32'(mul_v_in),  32'h0);
        chk("rst_mul_a",     32'(mul_a),     32'h0);
        chk("rst_mul_b",     32'(mul_b),     32'h0);
        chk("rst_mul_sm",    32'(mul_sm),    32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_p",     32'(rsp_p),     32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("rst_busy",      32'(busy),      32'h1);
`ifdef MUL_ARB_TAG_CHECK_EN
        chk("rst_tag_err",   32'(tag_err),   32'h0);
`endif
        for (int i = 0; i < 4; i++) set_op(i, 8'(i + 3), 8'(i + 5), 2'b00);
        rst = 1'b0;

        // All four valid: 8 drain cycles, then 0,1,2,3,0,1 back to back.
        drain_check("drain0");
        cycle(4'b1111, 4'b0001, 16'h000F, 1'b1);
        cycle(4'b1111, 4'b0010, 16'h0018, 1'b1);
        cycle(4'b1111, 4'b0100, 16'h0023, 1'b1);
        cycle(4'b1111, 4'b1000, 16'h0030, 1'b1);
        cycle(4'b1111, 4'b0001, 16'h000F, 1'b1);
        cycle(4'b1111, 4'b0010, 16'h0018, 1'b1);
        #1;
        chk("busy_inflight", 32'(busy), 32'd1);
        idle(12);
        chk("busy_idle0", 32'(busy), 32'd0);

        // Sign modes: -1*2 signed, 255*2 unsigned.
        set_op(2, 8'hFF, 8'h02, 2'b11);
        cycle(4'b0100, 4'b0100, 16'hFFFE, 1'b1);
        set_op(2, 8'hFF, 8'h02, 2'b00);
        cycle(4'b0100, 4'b0100, 16'h01FE, 1'b1);

        // ptr=0, then 0 and 3 valid: 3 wins, then 0; mixed sign modes.
        set_op(0, 8'h10, 8'h10, 2'b00);
        cycle(4'b0001, 4'b0001, 16'h0100, 1'b1);
        set_op(3, 8'h80, 8'h80, 2'b11);
        set_op(0, 8'h81, 8'h03, 2'b10);
        cycle(4'b1001, 4'b1000, 16'h4000, 1'b1);
        cycle(4'b1001, 4'b0001, 16'hFE83, 1'b1);

        // en low blocks grants; dropping valid leaves ptr alone.
        en = 1'b0;
        cycle(4'b1001, 4'b0000, 16'h0, 1'b0);
        cycle(4'b1111, 4'b0000, 16'h0, 1'b0);
        en = 1'b1;
        cycle(4'b0000, 4'b0000, 16'h0, 1'b0);
        cycle(4'b1001, 4'b1000, 16'h4000, 1'b1);
        idle(12);
        chk("busy_idle1", 32'(busy), 32'd0);

        // Reset with three requests in flight: all must be discarded.
        cycle(4'b0001, 4'b0001, 16'h0, 1'b0);
        cycle(4'b0010, 4'b0010, 16'h0, 1'b0);
        cycle(4'b0100, 4'b0100, 16'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_mul_v_in", 32'(mul_v_in), 32'h0);
        chk("async_busy",     32'(busy),     32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_op(0, 8'h03, 8'h05, 2'b00);
        drain_check("drain1");
        cycle(4'b1111, 4'b0001, 16'h000F, 1'b1);
        idle(12);
        chk("busy_idle2", 32'(busy), 32'd0);

`ifdef MUL_ARB_TAG_CHECK_EN
        // Spurious multiplier valid with no tag in flight.
        stub_force = 1'b1;
        idle(1);
        stub_force = 1'b0;
        idle(4);
        chk("tag_err_set", 32'(tag_err), 32'd1);
`endif

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
